// File: rtl/srm_data_mem_responder.sv
// Data-memory responder: captures one request, waits WAIT_CYCLES, then accesses a word RAM.
// mem_ack is high WAIT_CYCLES+2 cycles after capture. Inputs are ignored while busy.
module srm_data_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] dout,
  output logic [31:0] din,
  output logic        mem_ack,
  output logic        mem_err,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         din_q;
  logic                ram_we;
  logic                rd_en;
  logic                range_err;
  logic [31:0]         ram [2**ADDR_W];

  // Byte lanes are resolved by the datapath; only the word index matters here.
  logic unused_lanes;
  assign unused_lanes = ^d_addr[1:0];

  generate
    if (ADDR_W >= 30) begin : g_no_range_chk
      assign range_err = 1'b0;
    end else begin : g_range_chk
      assign range_err = |d_addr[31:ADDR_W+2];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    ram_we  = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          we_d    = mem_we;
          err_d   = range_err;
          idx_d   = d_addr[ADDR_W+1:2];
          wdata_d = dout;
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        ram_we  = we_q & ~err_q;
        rd_en   = ~we_q;
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  // Out-of-range loads return zero rather than stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q <= 32'd0;
    end else if (rd_en) begin
      din_q <= err_q ? 32'd0 : ram[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we && rst_n) begin
      ram[idx_q] <= wdata_q;
    end
  end

  assign din     = din_q;
  assign mem_ack = (state_q == S_RESP);
  assign mem_err = (state_q == S_RESP) & err_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_srm_data_mem_responder.sv
// Directed bench for srm_data_mem_responder with three wait-state configurations.
module tb_srm_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [2:0]        req;
  logic [2:0]        we;
  logic [2:0][31:0]  addr_v;
  logic [2:0][31:0]  wd_v;
  wire  [2:0][31:0]  din_w;
  wire  [2:0]        ack_w;
  wire  [2:0]        err_w;
  wire  [2:0]        busy_w;

  int n_vec = 0;
  int n_bad = 0;

  // index 0: WAIT_CYCLES=1, index 1: WAIT_CYCLES=0, index 2: WAIT_CYCLES=3
  srm_data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .mem_req(req[0]), .mem_we(we[0]), .d_addr(addr_v[0]),
    .dout(wd_v[0]), .din(din_w[0]), .mem_ack(ack_w[0]), .mem_err(err_w[0]), .busy(busy_w[0]));
  srm_data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .mem_req(req[1]), .mem_we(we[1]), .d_addr(addr_v[1]),
    .dout(wd_v[1]), .din(din_w[1]), .mem_ack(ack_w[1]), .mem_err(err_w[1]), .busy(busy_w[1]));
  srm_data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .mem_req(req[2]), .mem_we(we[2]), .d_addr(addr_v[2]),
    .dout(wd_v[2]), .din(din_w[2]), .mem_ack(ack_w[2]), .mem_err(err_w[2]), .busy(busy_w[2]));

  typedef struct {
    int          d;
    logic        w;
    logic [31:0] a;
    logic [31:0] data;
    logic [31:0] exp_din;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt [14];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one transaction, hold mem_req until ack, report din/err/latency.
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] data,
                     input string name, output logic [31:0] rdin, output logic rerr, output int lat);
    int busy_bad;
    busy_bad = 0;
    lat  = -1;
    rdin = 32'd0;
    rerr = 1'b0;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr_v[d] = a; wd_v[d] = data;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!busy_w[d]) busy_bad++;
      if (ack_w[d]) begin
        lat  = k;
        rdin = din_w[d];
        rerr = err_w[d];
        req[d] = 1'b0;
        break;
      end
    end
    check32({name, "_busy"}, busy_bad, 0);
    @(negedge clk);
    check32({name, "_after"}, {29'd0, ack_w[d], err_w[d], busy_w[d]}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        re;
    int          lat, lat2, acks;

    vt[0]  = '{0, 1'b1, 32'h0000_0000, 32'h0102_0304, 32'h0000_0000, 1'b0, 3};
    vt[1]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 3};
    vt[2]  = '{0, 1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0, 3};
    vt[3]  = '{0, 1'b1, 32'h0000_1000, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 3};
    vt[4]  = '{0, 1'b0, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1, 3};
    vt[5]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         32'h0102_0304, 1'b0, 3};
    vt[6]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 3};
    vt[7]  = '{0, 1'b0, 32'h8000_0000, 32'h0,         32'h0000_0000, 1'b1, 3};
    vt[8]  = '{1, 1'b1, 32'h0000_0004, 32'h5A5A_0001, 32'h0000_0000, 1'b0, 2};
    vt[9]  = '{1, 1'b0, 32'h0000_0004, 32'h0,         32'h5A5A_0001, 1'b0, 2};
    vt[10] = '{2, 1'b1, 32'h0000_0004, 32'h0000_FFFF, 32'h0000_0000, 1'b0, 5};
    vt[11] = '{2, 1'b0, 32'h0000_0004, 32'h0,         32'h0000_FFFF, 1'b0, 5};
    vt[12] = '{0, 1'b1, 32'h0000_0FFC, 32'h7E7E_7E7E, 32'h0000_0000, 1'b0, 3};
    vt[13] = '{0, 1'b0, 32'h0000_0FFF, 32'h0,         32'h7E7E_7E7E, 1'b0, 3};

    rst_n = 1'b0; req = '0; we = '0; addr_v = '0; wd_v = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check32($sformatf("reset_din%0d", d), din_w[d], 32'd0);
      check32($sformatf("reset_flags%0d", d), {29'd0, ack_w[d], err_w[d], busy_w[d]}, 32'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      txn(vt[i].d, vt[i].w, vt[i].a, vt[i].data, $sformatf("v%0d", i), rd, re, lat);
      check32($sformatf("v%0d_din", i), rd, vt[i].exp_din);
      check32($sformatf("v%0d_err", i), {31'd0, re}, {31'd0, vt[i].exp_err});
      check32($sformatf("v%0d_lat", i), lat, vt[i].exp_lat);
    end

    // Back-to-back stores with mem_req held high throughout.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr_v[0] = 32'h20; wd_v[0] = 32'h1111_1111;
    @(posedge clk);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack_w[0]) begin
        lat = k;
        addr_v[0] = 32'h24; wd_v[0] = 32'h2222_2222;
        break;
      end
    end
    check32("b2b_lat1", lat, 3);
    @(negedge clk);
    check32("b2b_dead", {30'd0, busy_w[0], ack_w[0]}, 32'd0);
    @(posedge clk);
    lat2 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack_w[0]) begin
        lat2 = k;
        req[0] = 1'b0;
        break;
      end
    end
    check32("b2b_lat2", lat2, 3);
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack_w[0]) acks++;
    end
    check32("b2b_no_extra_ack", acks, 0);
    txn(0, 1'b0, 32'h20, 32'h0, "b2b_ld20", rd, re, lat);
    check32("b2b_ld20_din", rd, 32'h1111_1111);
    txn(0, 1'b0, 32'h24, 32'h0, "b2b_ld24", rd, re, lat);
    check32("b2b_ld24_din", rd, 32'h2222_2222);

    // Request dropped one cycle after capture still completes.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr_v[0] = 32'h40; wd_v[0] = 32'hAAAA_5555;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    lat = -1;
    if (ack_w[0]) lat = 1;
    for (int k = 2; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (ack_w[0]) lat = k;
    end
    check32("drop_lat", lat, 3);
    txn(0, 1'b0, 32'h40, 32'h0, "drop_ld", rd, re, lat);
    check32("drop_ld_din", rd, 32'hAAAA_5555);

    // Reset during WAIT aborts the store.
    txn(0, 1'b1, 32'h80, 32'h0BAD_F00D, "rst_pre", rd, re, lat);
    txn(0, 1'b0, 32'h10, 32'h0, "rst_ld10", rd, re, lat);
    check32("rst_ld10_din", rd, 32'hDEAD_BEEF);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr_v[0] = 32'h80; wd_v[0] = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    check32("rst_in_wait_busy", {31'd0, busy_w[0]}, 32'd1);
    rst_n = 1'b0;
    req[0] = 1'b0;
    #1;
    check32("rst_abort_din", din_w[0], 32'd0);
    check32("rst_abort_flags", {29'd0, ack_w[0], err_w[0], busy_w[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_w[0]) acks++;
    end
    check32("rst_no_ack", acks, 0);
    txn(0, 1'b0, 32'h80, 32'h0, "rst_ld80", rd, re, lat);
    check32("rst_ld80_din", rd, 32'h0BAD_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
